// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch sequencer. It owns the PC, drives the combinational
//   instruction memory (4 KB, word-indexed by im_addr[11:2]), and captures the
//   returned word into the IF/ID pipeline register. It applies hazard stalls
//   and branch/jump redirects, and runs an IDLE/RUN/HALT run-control FSM.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   start        leave IDLE/HALT and begin fetching
//   halt_req     external request to stop fetching
//   stall        hazard-unit hold of PC and IF/ID
//   redirect     branch/jump taken; flush IF/ID and load redirect_pc
//   redirect_pc  redirect target (low two bits are ignored)
//   im_addr      instruction memory address (equals pc, combinational)
//   im_instr     instruction word returned combinationally by memory
//   ifid_instr   IF/ID instruction
//   ifid_pc4     IF/ID PC+4 of that instruction
//   ifid_valid   IF/ID holds a real instruction (0 = bubble)
//   running      state == RUN
//   halted       state == HALT
//   fetch_count  instructions delivered to IF/ID (saturating)
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      im_addr,
  input  logic [31:0]      im_instr,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      ifid_instr_reg, ifid_instr_next;
  logic [31:0]      ifid_pc4_reg, ifid_pc4_next;
  logic             ifid_valid_reg, ifid_valid_next;
  logic [CNT_W-1:0] fetch_count_reg, fetch_count_next;

  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_target;

  // 32-bit modulo add: 0xFFFF_FFFC wraps to 0.
  assign pc_plus4        = pc_reg + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_PC;
      ifid_instr_reg  <= '0;
      ifid_pc4_reg    <= '0;
      ifid_valid_reg  <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      ifid_instr_reg  <= ifid_instr_next;
      ifid_pc4_reg    <= ifid_pc4_next;
      ifid_valid_reg  <= ifid_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    ifid_instr_next  = ifid_instr_reg;
    ifid_pc4_next    = ifid_pc4_reg;
    ifid_valid_next  = ifid_valid_reg;
    fetch_count_next = fetch_count_reg;

    case (state_reg)
      ST_RUN: begin
        if (redirect) begin
          // A flush beats a stall. A simultaneous halt request still halts,
          // but a HALT_INSTR fetched this cycle is on the wrong path and is
          // simply dropped.
          pc_next         = redirect_target;
          ifid_valid_next = 1'b0;
          if (halt_req) begin
            state_next = ST_HALT;
          end
        end else if (stall) begin
          // Hold everything; a HALT_INSTR under stall is re-examined later.
        end else if (halt_req || (im_instr == HALT_INSTR)) begin
          // pc stays put so a later start resumes at the same address.
          state_next      = ST_HALT;
          ifid_valid_next = 1'b0;
        end else begin
          ifid_instr_next = im_instr;
          ifid_pc4_next   = pc_plus4;
          ifid_valid_next = 1'b1;
          pc_next         = pc_plus4;
          if (fetch_count_reg != '1) begin
            fetch_count_next = fetch_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        // IDLE and HALT: no fetch, stall ignored, redirect still steers pc
        // so the first fetch after start comes from the new target.
        ifid_valid_next = 1'b0;
        if (redirect) begin
          pc_next = redirect_target;
        end
        if (start) begin
          state_next = ST_RUN;
        end
      end
    endcase
  end

  assign im_addr     = pc_reg;
  assign ifid_instr  = ifid_instr_reg;
  assign ifid_pc4    = ifid_pc4_reg;
  assign ifid_valid  = ifid_valid_reg;
  assign fetch_count = fetch_count_reg;
  assign running     = (state_reg == ST_RUN);
  assign halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Directed walk through the fetch scenarios followed by randomized
//   start/halt/stall/redirect traffic, all checked cycle by cycle against a
//   behavioural model of the fetch unit. A narrow fetch counter is used so
//   the saturation boundary is reached during the random phase.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  localparam int          CW       = 6;
  localparam logic [31:0] HALT_W   = 32'h0000_000C;
  localparam logic [31:0] RST_PC   = 32'h0000_3000;
  localparam int          CNT_MAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, halt_req, stall, redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   im_addr, im_instr, ifid_instr, ifid_pc4;
  logic          ifid_valid, running, halted;
  logic [CW-1:0] fetch_count;

  logic [31:0]   mem [1024];

  assign im_instr = mem[im_addr[11:2]];

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .RESET_PC  (RST_PC),
    .HALT_INSTR(HALT_W),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .im_addr    (im_addr),
    .im_instr   (im_instr),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .running    (running),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  // Behavioural model: mode is 0 idle, 1 run, 2 halt.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_count;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = RST_PC;
    m_instr = '0;
    m_pc4   = '0;
    m_valid = 1'b0;
    m_count = 0;
  endtask

  // One clock of architectural behaviour, evaluated from the inputs as they
  // stand just before the edge.
  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc[11:2]];
    if (m_mode == 1) begin
      if (redirect) begin
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_valid = 1'b0;
        if (halt_req) m_mode = 2;
      end else if (stall) begin
        // frozen
      end else if (halt_req || word == HALT_W) begin
        m_mode  = 2;
        m_valid = 1'b0;
      end else begin
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        if (m_count < CNT_MAX) m_count++;
      end
    end else begin
      m_valid = 1'b0;
      if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
      if (start) m_mode = 1;
    end
  endtask

  task automatic check_all();
    chk("im_addr",     im_addr,            m_pc);
    chk("ifid_instr",  ifid_instr,         m_instr);
    chk("ifid_pc4",    ifid_pc4,           m_pc4);
    chk("ifid_valid",  {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("running",     {31'd0, running},   {31'd0, m_mode == 1});
    chk("halted",      {31'd0, halted},    {31'd0, m_mode == 2});
    chk("fetch_count", {{(32-CW){1'b0}}, fetch_count}, m_count);
  endtask

  // Drive one cycle of inputs, step the model, clock, then compare.
  task automatic cyc(input logic s, input logic h, input logic st,
                     input logic r, input logic [31:0] rp);
    start = s; halt_req = h; stall = st; redirect = r; redirect_pc = rp;
    model_step();
    @(posedge clk);
    #1;
    $display("t=%0t s=%b h=%b st=%b r=%b rp=%h | pc=%h v=%b instr=%h pc4=%h run=%b hlt=%b cnt=%0d",
             $time, s, h, st, r, rp, im_addr, ifid_valid, ifid_instr, ifid_pc4,
             running, halted, fetch_count);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_W) mem[i] = mem[i] ^ 32'h1;
    end
    mem[0] = 32'h2008_0005;
    mem[3] = HALT_W;

    // Reset
    rst = 1'b0; start = 0; halt_req = 0; stall = 0; redirect = 0; redirect_pc = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // Start, then first fetch
    cyc(1, 0, 0, 0, '0);
    chk("start_no_fetch", {31'd0, ifid_valid}, 32'd0);
    cyc(0, 0, 0, 0, '0);
    chk("first_instr", ifid_instr, 32'h2008_0005);
    chk("first_pc4",   ifid_pc4,   32'h0000_3004);
    chk("first_pc",    im_addr,    32'h0000_3004);
    chk("first_cnt",   {{(32-CW){1'b0}}, fetch_count}, 32'd1);
    cyc(0, 0, 0, 0, '0);

    // Three-cycle stall at 0x3008
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, '0);
      chk("stall_pc", im_addr, 32'h0000_3008);
    end
    cyc(0, 0, 0, 0, '0);
    chk("after_stall_instr", ifid_instr, mem[2]);

    // Redirect under stall while the HALT word is being fetched at 0x300C
    cyc(0, 0, 1, 1, 32'h0000_3023);
    chk("redir_pc",    im_addr, 32'h0000_3020);
    chk("redir_nohalt", {31'd0, running}, 32'd1);
    cyc(0, 0, 0, 0, '0);
    chk("redir_deliver", ifid_pc4, 32'h0000_3024);

    // Walk into the HALT word
    cyc(0, 0, 0, 1, 32'h0000_3008);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    chk("halt_instr_halted", {31'd0, halted}, 32'd1);
    chk("halt_instr_pc",     im_addr, 32'h0000_300C);
    cyc(0, 0, 1, 0, '0);
    cyc(1, 0, 0, 0, '0);
    chk("restart_pc", im_addr, 32'h0000_300C);
    cyc(0, 0, 0, 0, '0);

    // Start with redirect from HALT, then halt_req together with redirect
    cyc(1, 0, 0, 1, 32'h0000_3040);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 1, 32'h0000_3100);
    chk("halt_redir_pc", im_addr, 32'h0000_3100);

    // PC wrap at the top of the address space
    cyc(0, 0, 0, 1, 32'hFFFF_FFFE);
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    chk("wrap_pc",  im_addr,  32'h0000_0000);
    chk("wrap_pc4", ifid_pc4, 32'h0000_0000);

    // Asynchronous reset while running at 0x3040
    cyc(0, 0, 0, 1, 32'h0000_3040);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    rst = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rp;
      if ($urandom_range(0, 3) == 0) rp = $urandom;
      else rp = 32'h0000_3000 + $urandom_range(0, 255);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
